// File: rtl/counter_checker_pkg.sv
// counter_checker_pkg: shared FSM state type and error-counter width for counter_checker
package counter_checker_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, CHECK, FAIL} state_t;
  localparam int ERR_W = 8;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter, no wrap
//   clk, res (async active-low), inc (count up), clr (sync clear) -> q
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         res,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge res)
    if (!res) q <= '0;
    else if (clr) q <= '0;
    else if (inc && q != '1) q <= q + W'(1);
endmodule

// File: rtl/counter_checker.sv
// counter_checker: locks onto an observed binary counter and flags deviations from its expected sequence
//   clk, res (async active-low), en, cnt_in -> exp_cnt, locked, mismatch (1-cycle pulse), err_cnt, fail (sticky)
//   CNT_CHK_WRAP_COV_EN adds wrap_cnt: matching all-ones samples with en seen while locked
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CYC = 4,
  parameter int MAX_ERR  = 3
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] exp_cnt,
  output logic             locked,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail
`ifdef CNT_CHK_WRAP_COV_EN
  ,
  output logic [ERR_W-1:0] wrap_cnt
`endif
);
  localparam logic [3:0] LC = 4'(LOCK_CYC);
  state_t st;
  logic [3:0] lock_cnt;
  logic [WIDTH-1:0] nxt;
  logic match, active, miss, err_hit;
  assign nxt = cnt_in + {{(WIDTH-1){1'b0}}, en};
  assign match = cnt_in == exp_cnt;
  assign active = st == CHECK || st == FAIL;
  assign miss = active && !match;
  // err_cnt increments on this same edge, so reaching MAX_ERR means it currently holds MAX_ERR-1
  assign err_hit = miss && err_cnt == ERR_W'(MAX_ERR - 1);
  always_ff @(posedge clk or negedge res)
    if (!res) begin
      st       <= IDLE;
      exp_cnt  <= '0;
      locked   <= 1'b0;
      mismatch <= 1'b0;
      fail     <= 1'b0;
      lock_cnt <= '0;
    end else begin
      mismatch <= miss;
      // on a match cnt_in equals exp_cnt, so nxt is exp_cnt + en; on a mismatch it resyncs
      exp_cnt  <= nxt;
      case (st)
        IDLE: begin
          lock_cnt <= '0;
          st       <= SYNC;
        end
        SYNC: begin
          lock_cnt <= match ? lock_cnt + 4'd1 : 4'd0;
          if (match && lock_cnt + 4'd1 == LC) begin
            st     <= CHECK;
            locked <= 1'b1;
          end
        end
        default:
          if (err_hit) begin
            st   <= FAIL;
            fail <= 1'b1;
          end
      endcase
    end
  sat_counter #(.W(ERR_W)) u_err (
    .clk(clk), .res(res), .inc(miss), .clr(1'b0), .q(err_cnt)
  );
`ifdef CNT_CHK_WRAP_COV_EN
  sat_counter #(.W(ERR_W)) u_wrap (
    .clk(clk), .res(res), .inc(active && match && en && cnt_in == '1), .clr(1'b0), .q(wrap_cnt)
  );
`endif
endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: directed self-checking bench for counter_checker (WIDTH=4, LOCK_CYC=4, MAX_ERR=3)
module tb_counter_checker;
  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       en = 1'b0;
  logic [3:0] cnt_in = '0;
  logic [3:0] exp_cnt;
  logic       locked, mismatch, fail;
  logic [7:0] err_cnt;
`ifdef CNT_CHK_WRAP_COV_EN
  logic [7:0] wrap_cnt;
`endif
  int n_run = 0;
  int n_fail = 0;
  logic seen_mm = 1'b0;

  counter_checker #(.WIDTH(4), .LOCK_CYC(4), .MAX_ERR(3)) dut (
    .clk(clk), .res(res), .en(en), .cnt_in(cnt_in), .exp_cnt(exp_cnt),
    .locked(locked), .mismatch(mismatch), .err_cnt(err_cnt), .fail(fail)
`ifdef CNT_CHK_WRAP_COV_EN
    , .wrap_cnt(wrap_cnt)
`endif
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // inputs change 1 ns after a rising edge; outputs are read 1 ns after the next one
  task automatic step(input logic [3:0] c, input logic e);
    cnt_in = c;
    en = e;
    @(posedge clk);
    #1 seen_mm = seen_mm | mismatch;
  endtask

  // 10 ns low pulse placed entirely between two rising edges
  task automatic do_reset();
    @(posedge clk);
    #1 res = 1'b0;
    #1;
    chk("rst_exp", 32'(exp_cnt), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_mm", 32'(mismatch), 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_fail", 32'(fail), 0);
    #9 res = 1'b1;
    seen_mm = 1'b0;
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 4; i++) step(4'(i), 1'b1);
    chk("a_not_locked_e4", 32'(locked), 0);
    step(4'd4, 1'b1);
    chk("a_locked_e5", 32'(locked), 1);
    step(4'd5, 1'b1);
    chk("a_exp", 32'(exp_cnt), 6);
    chk("a_no_mm", 32'(seen_mm), 0);
    chk("a_err", 32'(err_cnt), 0);

    for (int i = 6; i < 16; i++) step(4'(i), 1'b1);
    step(4'd0, 1'b1);
    step(4'd1, 1'b1);
    chk("b_no_mm_wrap", 32'(seen_mm), 0);
    chk("b_exp", 32'(exp_cnt), 2);
    chk("b_err", 32'(err_cnt), 0);
`ifdef CNT_CHK_WRAP_COV_EN
    chk("b_wrap_cnt", 32'(wrap_cnt), 1);
`endif

    for (int i = 2; i < 6; i++) step(4'(i), 1'b1);
    for (int i = 0; i < 3; i++) step(4'd6, 1'b0);
    chk("c_hold_exp", 32'(exp_cnt), 6);
    chk("c_hold_no_mm", 32'(seen_mm), 0);
    step(4'd7, 1'b0);
    chk("c_mm", 32'(mismatch), 1);
    chk("c_err", 32'(err_cnt), 1);
    chk("c_exp", 32'(exp_cnt), 7);
    step(4'd7, 1'b0);
    chk("c_mm_one_cycle", 32'(mismatch), 0);
    chk("c_err_hold", 32'(err_cnt), 1);

    do_reset();
    for (int i = 0; i < 8; i++) step(4'(i), 1'b1);
    chk("d_exp8", 32'(exp_cnt), 8);
    step(4'd11, 1'b1);
    chk("d_g1_mm", 32'(mismatch), 1);
    chk("d_g1_err", 32'(err_cnt), 1);
    chk("d_g1_exp", 32'(exp_cnt), 12);
    chk("d_g1_fail", 32'(fail), 0);
    step(4'd12, 1'b1);
    chk("d_clean1", 32'(mismatch), 0);
    step(4'd0, 1'b1);
    chk("d_g2_err", 32'(err_cnt), 2);
    chk("d_g2_fail", 32'(fail), 0);
    step(4'd1, 1'b1);
    step(4'd9, 1'b1);
    chk("d_g3_mm", 32'(mismatch), 1);
    chk("d_g3_err", 32'(err_cnt), 3);
    chk("d_g3_fail", 32'(fail), 1);
    chk("d_g3_locked", 32'(locked), 1);
    seen_mm = 1'b0;
    step(4'd10, 1'b1);
    step(4'd11, 1'b1);
    chk("d_post_no_mm", 32'(seen_mm), 0);
    chk("d_post_err", 32'(err_cnt), 3);
    chk("d_post_fail", 32'(fail), 1);
    chk("d_post_exp", 32'(exp_cnt), 12);
    step(4'd3, 1'b1);
    chk("d_fail_still_counts", 32'(err_cnt), 4);

    do_reset();
    for (int i = 0; i < 5; i++) step(4'(i), 1'b1);
    step(4'd9, 1'b1);
    step(4'd10, 1'b1);
    step(4'd0, 1'b1);
    step(4'd1, 1'b1);
    chk("e_err2", 32'(err_cnt), 2);
    chk("e_locked", 32'(locked), 1);
    do_reset();
    for (int i = 0; i < 4; i++) step(4'(i), 1'b1);
    chk("e_relock_e4", 32'(locked), 0);
    step(4'd4, 1'b1);
    chk("e_relock_e5", 32'(locked), 1);
    chk("e_err_after", 32'(err_cnt), 0);

    do_reset();
    step(4'd0, 1'b1);
    step(4'd1, 1'b1);
    step(4'd2, 1'b1);
    step(4'd9, 1'b1);
    for (int i = 10; i < 13; i++) step(4'(i), 1'b1);
    chk("f_not_locked_e7", 32'(locked), 0);
    step(4'd13, 1'b1);
    chk("f_locked_e8", 32'(locked), 1);
    chk("f_err", 32'(err_cnt), 0);
    chk("f_no_mm", 32'(seen_mm), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
